// File: rtl/mii_mac_pkg.sv
// mii_mac_pkg: shared MII MAC constants and the TX serializer state encoding.
package mii_mac_pkg;
   localparam logic [3:0] PREAMBLE_NIBBLE = 4'h5;
   localparam logic [3:0] SFD_NIBBLE = 4'hD;
   localparam int DEFAULT_IFG_NIBBLES = 24;
   typedef enum logic [3:0] {
      S_RESET,
      S_IDLE,
      S_PREAMBLE,
      S_SFD,
      S_DATA_LO,
      S_DATA_HI,
      S_UNDERRUN,
      S_DRAIN,
      S_IFG
   } state_t;
endpackage

// File: rtl/mii_tx_nibble.sv
// mii_tx_nibble: AXI-Stream byte frames to MII TX nibbles with preamble, SFD,
// TX_ER for errored/underrun bytes and a guaranteed inter-frame gap.
module mii_tx_nibble
   import mii_mac_pkg::*;
#(
   parameter int PREAMBLE_NIBBLES = 15,
   parameter int IFG_NIBBLES = DEFAULT_IFG_NIBBLES
) (
   input  logic       clock,
   input  logic       aresetn,
   input  logic [7:0] saxis_tdata,
   input  logic       saxis_tvalid,
   output logic       saxis_tready,
   input  logic       saxis_tlast,
   input  logic       saxis_tuser,
   output logic [3:0] mii_txd,
   output logic       mii_tx_en,
   output logic       mii_tx_er,
   output logic       underrun
);
   localparam int CW = $clog2(PREAMBLE_NIBBLES > IFG_NIBBLES ? PREAMBLE_NIBBLES : IFG_NIBBLES);
   // IFG loads one short: the state after S_IFG and the registered output lag supply the rest.
   localparam logic [CW-1:0] PRE_LOAD = CW'(PREAMBLE_NIBBLES - 1);
   localparam logic [CW-1:0] IFG_LOAD = CW'(IFG_NIBBLES - 2);

   state_t state;
   logic [CW-1:0] cnt;
   logic [7:0] byte_q;
   logic last_q;
   logic user_q;
   logic data_state;

   assign data_state = state == S_DATA_LO || state == S_DATA_HI;
   assign saxis_tready = state == S_SFD || state == S_DRAIN || (state == S_DATA_HI && !last_q);

   always_ff @(posedge clock) begin
      if (!aresetn) begin
         state <= S_RESET;
         cnt <= '0;
         byte_q <= '0;
         last_q <= 1'b0;
         user_q <= 1'b0;
         mii_txd <= '0;
         mii_tx_en <= 1'b0;
         mii_tx_er <= 1'b0;
         underrun <= 1'b0;
      end else begin
         mii_txd <= state == S_PREAMBLE ? PREAMBLE_NIBBLE :
                    state == S_SFD      ? SFD_NIBBLE :
                    state == S_DATA_LO  ? byte_q[3:0] :
                    state == S_DATA_HI  ? byte_q[7:4] : 4'h0;
         mii_tx_en <= state inside {S_PREAMBLE, S_SFD, S_DATA_LO, S_DATA_HI, S_UNDERRUN};
         mii_tx_er <= (data_state && user_q) || state == S_UNDERRUN;
         underrun <= state == S_UNDERRUN;
         case (state)
            S_RESET: begin
               cnt <= IFG_LOAD;
               state <= S_IFG;
            end
            S_IDLE: if (saxis_tvalid) begin
               cnt <= PRE_LOAD;
               state <= S_PREAMBLE;
            end
            S_PREAMBLE: if (cnt == '0) state <= S_SFD; else cnt <= cnt - 1'b1;
            S_SFD: begin
               byte_q <= saxis_tdata;
               last_q <= saxis_tlast;
               user_q <= saxis_tuser;
               state <= S_DATA_LO;
            end
            S_DATA_LO: state <= S_DATA_HI;
            S_DATA_HI: begin
               if (last_q) begin
                  cnt <= IFG_LOAD;
                  state <= S_IFG;
               end else if (saxis_tvalid) begin
                  byte_q <= saxis_tdata;
                  last_q <= saxis_tlast;
                  user_q <= saxis_tuser;
                  state <= S_DATA_LO;
               end else begin
                  state <= S_UNDERRUN;
               end
            end
            S_UNDERRUN: state <= S_DRAIN;
            S_DRAIN: if (saxis_tvalid && saxis_tlast) begin
               cnt <= IFG_LOAD;
               state <= S_IFG;
            end
            S_IFG: if (cnt == '0) state <= S_IDLE; else cnt <= cnt - 1'b1;
            default: state <= S_RESET;
         endcase
      end
   end
endmodule

// File: doc/mii_tx_nibble.md
# mii_tx_nibble

Transmit-side MII serializer for the MAC TX path. It consumes complete Ethernet frames (destination address through FCS) as an 8-bit AXI-Stream from the CRC-append stage. It drives the PHY MII transmit pins: preamble, SFD, data low-nibble-first, and a guaranteed inter-frame gap. It runs entirely in the PHY TX_CLK domain and flags upstream underruns and errored bytes with TX_ER.

## Interface
- `PREAMBLE_NIBBLES`, 15: number of 0x5 nibbles sent before the SFD nibble.
- `IFG_NIBBLES`, 24: minimum count of TX_EN-low cycles between frames (96 bit times).
- `clock` in 1: MII TX_CLK (25 MHz / 2.5 MHz); the only clock.
- `aresetn` in 1: reset, synchronous, active-low.
- `saxis_tdata` in 8: frame byte.
- `saxis_tvalid` in 1: byte valid.
- `saxis_tready` out 1: byte accepted when high with tvalid.
- `saxis_tlast` in 1: last byte (final FCS byte) of frame.
- `saxis_tuser` in 1: byte errored; transmit it with TX_ER.
- `mii_txd` out 4: MII TXD.
- `mii_tx_en` out 1: MII TX_EN.
- `mii_tx_er` out 1: MII TX_ER.
- `underrun` out 1: one-cycle pulse when upstream fails to supply a mid-frame byte.

## Operation
- States: S_RESET, S_IDLE, S_PREAMBLE, S_SFD, S_DATA_LO, S_DATA_HI, S_UNDERRUN, S_DRAIN, S_IFG.
- S_RESET: one cycle, then load the IFG counter and go to S_IFG. This produces a full gap after any reset, including one that truncates a frame.
- S_IDLE: tready=0. When tvalid=1, go to S_PREAMBLE. The byte is not consumed here.
- S_PREAMBLE: txd=0x5 for PREAMBLE_NIBBLES cycles, then S_SFD.
- S_SFD: txd=0xD, tready=1.
  - The first byte is always present because AXIS tvalid cannot drop once asserted.
  - Capture data/last/user into the byte register; go to S_DATA_LO.
- S_DATA_LO: txd=byte[3:0]; tx_er=user.
- S_DATA_HI: txd=byte[7:4]; tx_er=user; tready=!last.
  - last=1: go to S_IFG.
  - last=0 and tvalid=1: capture the next byte; go to S_DATA_LO.
  - last=0 and tvalid=0: go to S_UNDERRUN.
- S_UNDERRUN: one cycle, tx_en=1, tx_er=1, txd=0x0; underrun=1; go to S_DRAIN.
- S_DRAIN: tx_en=0, tready=1. Discard bytes until a byte with tlast is accepted, then go to S_IFG.
- S_IFG: tx_en=0; stay IFG_NIBBLES-1 cycles, then go to S_IDLE.
- MII outputs and underrun are registered: the values listed per state appear on the pins one cycle after entering that state.
- Outside a frame: txd=0, tx_en=0, tx_er=0.

## Timing
- Reset values: mii_txd=0, mii_tx_en=0, mii_tx_er=0, underrun=0, saxis_tready=0.
- Reset mid-frame: tx_en drops at the edge where aresetn is sampled low. Input bytes are not drained; upstream is reset by the same signal.
- Start latency: tvalid seen in S_IDLE at cycle 0 gives preamble on the pins at cycles 2..16, SFD at cycle 17, first low nibble at cycle 18.
- Throughput: exactly one byte accepted per 2 cycles during data; tready is never high in two consecutive cycles inside a frame.
- saxis_tready is combinational from state and the byte register only; it never depends on tvalid.
- Gap: tx_en low for at least IFG_NIBBLES cycles between the last data nibble and the next preamble nibble. The gap is exactly IFG_NIBBLES when the next tvalid is already high.
- Frame length is unbounded; there is no internal byte counter and no minimum-size padding (padding is done upstream).
- Counters are sized with $clog2 of max(PREAMBLE_NIBBLES, IFG_NIBBLES).

## Structure
- Shared package `mii_mac_pkg`:
  - constants PREAMBLE_NIBBLE=4'h5 and SFD_NIBBLE=4'hD;
  - default IFG_NIBBLES;
  - the mii_tx state_t enum.
- Single module, no sub-module. One down-counter is shared between the preamble and IFG states.

## Test plan
- One-byte frame 0xA5, tlast=1 -> tx_en=1 for 18 cycles: 15×0x5, 0xD, 0x5, 0xA; tx_er=0 throughout; then ≥24 cycles tx_en=0.
- Back-to-back 64-byte frames, tvalid held high -> exactly 24 tx_en-low cycles between frames; all 128 nibbles of each frame match low-then-high order.
- tuser=1 on byte 3 (0x3C) of a 10-byte frame -> tx_er=1 on exactly the two nibbles 0xC and 0x3; every other nibble has tx_er=0.
- tvalid dropped before byte 5 of a 20-byte frame -> one nibble with tx_en=1, tx_er=1, txd=0; underrun pulse; remaining bytes consumed through tlast with tx_en=0; 24-cycle gap; next frame is clean.
- aresetn low for 1 cycle during data nibble 7 -> all outputs 0 on the next edge; no tx_en for ≥24 cycles afterwards; the following frame is correct.
- Random tvalid gaps only before SFD -> no underrun; tready pulses spaced exactly 2 cycles apart within a frame.
